// File: rtl/bitbakery_input_conditioner.sv
// Pushbutton front end: a 2-flop synchronizer and a debounce FSM per channel, plus a latched one-hot "last play" register.
// Optional build macro BITBAKERY_AUTOREPEAT_EN adds held-button auto-repeat pulses on the 7 game buttons.
module bitbakery_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes_in,
  input  logic       iniciar_in,
  input  logic       zera_jogada,
  output logic [6:0] botoes,
  output logic [6:0] botoes_pulse,
  output logic       iniciar,
  output logic       iniciar_pulse,
  output logic       tem_jogada,
  output logic [6:0] jogada
);

  localparam int NCH = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_param
    $error("bitbakery_input_conditioner: illegal parameter combination");
  end

  logic [NCH-1:0] pressed_raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] level, pulse;
  logic [6:0]     jogada_q, jogada_d;

  // Channel 7 carries iniciar; all buttons are inverted to active-high first.
  assign pressed_raw = {~iniciar_in, ~botoes_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // state       | meaning
    // SOLTO       | released, idle
    // CONF_PRESS  | confirming a press, counting stable 1 samples
    // PRESSIONADO | pressed, level held high
    // CONF_SOLTO  | confirming a release, counting stable 0 samples
    typedef enum logic [1:0] {SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTO} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q, pls_q;
    logic             sample;

    assign sample = sync2_q[g];

`ifdef BITBAKERY_AUTOREPEAT_EN
    localparam bit REP_EN = (g < 7);
    logic [REP_W-1:0] rep_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= SOLTO;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        pls_q   <= 1'b0;
`ifdef BITBAKERY_AUTOREPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        pls_q <= 1'b0;
        case (state_q)
          SOLTO: begin
            cnt_q <= '0;
            if (sample) begin
              if (LAST == '0) begin
                state_q <= PRESSIONADO;
                lvl_q   <= 1'b1;
                pls_q   <= 1'b1;
              end else begin
                state_q <= CONF_PRESS;
              end
            end
          end
          CONF_PRESS: begin
            if (!sample) begin
              cnt_q   <= '0;
              state_q <= SOLTO;
            end else if (cnt_q + 1'b1 == LAST) begin
              cnt_q   <= '0;
              state_q <= PRESSIONADO;
              lvl_q   <= 1'b1;
              pls_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PRESSIONADO: begin
            cnt_q <= '0;
            if (!sample) begin
              if (LAST == '0) begin
                state_q <= SOLTO;
                lvl_q   <= 1'b0;
              end else begin
                state_q <= CONF_SOLTO;
              end
            end
          end
          CONF_SOLTO: begin
            if (sample) begin
              cnt_q   <= '0;
              state_q <= PRESSIONADO;
            end else if (cnt_q + 1'b1 == LAST) begin
              cnt_q   <= '0;
              state_q <= SOLTO;
              lvl_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= SOLTO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
`ifdef BITBAKERY_AUTOREPEAT_EN
        // Reloaded on every cycle outside a held PRESSIONADO, so any exit restarts the delay.
        if (REP_EN && state_q == PRESSIONADO && sample) begin
          if (rep_q == '0) begin
            pls_q <= 1'b1;
            rep_q <= REP_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_q <= rep_q - 1'b1;
          end
        end else begin
          rep_q <= REP_W'(REPEAT_DELAY - 1);
        end
`endif
      end
    end

    assign level[g] = lvl_q;
    assign pulse[g] = pls_q;
  end

  assign botoes        = level[6:0];
  assign botoes_pulse  = pulse[6:0];
  assign iniciar       = level[7];
  assign iniciar_pulse = pulse[7];
  assign tem_jogada    = |botoes_pulse;

  // Lowest set bit of the pulse vector: x & -x.
  always_comb begin
    jogada_d = jogada_q;
    if (tem_jogada)       jogada_d = botoes_pulse & (~botoes_pulse + 7'd1);
    else if (zera_jogada) jogada_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) jogada_q <= '0;
    else        jogada_q <= jogada_d;
  end

  assign jogada = jogada_q;

endmodule

// File: tb/tb_bitbakery_input_conditioner.sv
// Bench for bitbakery_input_conditioner: directed scenarios plus random button activity against a run-length debounce model.
module tb_bitbakery_input_conditioner;

  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
`ifdef BITBAKERY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] botoes_in;
  logic       iniciar_in;
  logic       zera_jogada;
  logic [6:0] botoes, botoes_pulse, jogada;
  logic       iniciar, iniciar_pulse, tem_jogada;

  bitbakery_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .botoes_in(botoes_in), .iniciar_in(iniciar_in),
    .zera_jogada(zera_jogada), .botoes(botoes), .botoes_pulse(botoes_pulse),
    .iniciar(iniciar), .iniciar_pulse(iniciar_pulse), .tem_jogada(tem_jogada),
    .jogada(jogada)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: a level flips once D consecutive synchronized samples disagree with it.
  bit [7:0] m_lvl, m_pulse, p1, p2;
  int       m_run [8];
  int       m_t   [8];
  bit [6:0] m_jog;
  int       pcount [8];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit [6:0] lowest(input bit [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return 7'(1 << i);
    return 7'd0;
  endfunction

  task automatic model_clear();
    m_lvl = '0; m_pulse = '0; p1 = '0; p2 = '0; m_jog = '0;
    for (int c = 0; c < 8; c++) begin m_run[c] = 0; m_t[c] = 0; end
  endtask

  task automatic step();
    bit [7:0] pr;
    bit       z, s;
    pr = {~iniciar_in, ~botoes_in};
    z  = zera_jogada;
    @(posedge clock);
    if (|m_pulse[6:0]) m_jog = lowest(m_pulse[6:0]);
    else if (z)        m_jog = '0;
    for (int c = 0; c < 8; c++) begin
      s = p2[c];
      m_pulse[c] = 1'b0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = s;
          m_run[c] = 0;
          if (s) begin m_pulse[c] = 1'b1; m_t[c] = 0; end
        end
      end else begin
        if (s) begin
          if (m_run[c] > 0) m_t[c] = 0;
          else begin
            m_t[c]++;
            if (AR && c < 7 && m_t[c] >= RD && (m_t[c] - RD) % RP == 0) m_pulse[c] = 1'b1;
          end
        end
        m_run[c] = 0;
      end
    end
    p2 = p1;
    p1 = pr;
    #1;
    for (int c = 0; c < 7; c++) if (botoes_pulse[c]) pcount[c]++;
    if (iniciar_pulse) pcount[7]++;
    chk("botoes",        {1'b0, botoes},       {1'b0, m_lvl[6:0]});
    chk("botoes_pulse",  {1'b0, botoes_pulse}, {1'b0, m_pulse[6:0]});
    chk("iniciar",       {7'd0, iniciar},      {7'd0, m_lvl[7]});
    chk("iniciar_pulse", {7'd0, iniciar_pulse},{7'd0, m_pulse[7]});
    chk("tem_jogada",    {7'd0, tem_jogada},   {7'd0, |m_pulse[6:0]});
    chk("jogada",        {1'b0, jogada},       {1'b0, m_jog});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 8; c++) pcount[c] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_botoes"}, {1'b0, botoes}, 8'h00);
    chk({tag, "_pulse"},  {1'b0, botoes_pulse}, 8'h00);
    chk({tag, "_ini"},    {6'd0, iniciar, iniciar_pulse}, 8'h00);
    chk({tag, "_jog"},    {tem_jogada, jogada}, 8'h00);
  endtask

  initial begin
    reset = 1'b0; botoes_in = 7'h7f; iniciar_in = 1'b1; zera_jogada = 1'b0;
    model_clear(); clear_counts();
    repeat (3) @(posedge clock);
    #1 chk_all_zero("reset_state");
    #2 reset = 1'b1;
    steps(4);

    // Clean press on button 2
    botoes_in[2] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 5) chk("press2_edge5", {1'b0, botoes_pulse}, 8'h00);
      if (i == 6) begin
        chk("press2_pulse", {1'b0, botoes_pulse}, 8'h04);
        chk("press2_level", {7'd0, botoes[2]}, 8'h01);
        chk("press2_tem", {7'd0, tem_jogada}, 8'h01);
      end
      if (i == 7) begin
        chk("press2_jog", {1'b0, jogada}, 8'h04);
        chk("press2_once", {7'd0, tem_jogada}, 8'h00);
      end
    end
    botoes_in[2] = 1'b1;
    steps(10);

    // Bounce on button 0
    clear_counts();
    botoes_in[0] = 1'b0; steps(3);
    botoes_in[0] = 1'b1; steps(1);
    botoes_in[0] = 1'b0;
    steps(5);
    chk("bounce_nopulse", 8'(pcount[0]), 8'd0);
    step();
    chk("bounce_pulse6", {7'd0, botoes_pulse[0]}, 8'h01);
    steps(4);
    chk("bounce_count", 8'(pcount[0]), 8'd1);
    botoes_in[0] = 1'b1; steps(10);

    // Simultaneous press of 5 and 1, with zera in the load cycle
    botoes_in[5] = 1'b0; botoes_in[1] = 1'b0;
    steps(6);
    chk("simul_pulse", {1'b0, botoes_pulse}, 8'h22);
    zera_jogada = 1'b1;
    step();
    chk("simul_jog", {1'b0, jogada}, 8'h02);
    zera_jogada = 1'b0;
    steps(2);
    zera_jogada = 1'b1; step(); zera_jogada = 1'b0;
    chk("zera_clears", {1'b0, jogada}, 8'h00);
    botoes_in[5] = 1'b1; botoes_in[1] = 1'b1; steps(10);

    // Long hold of button 3, release with a 2-cycle glitch
    botoes_in[3] = 1'b0; steps(20);
    clear_counts();
    botoes_in[3] = 1'b1; steps(2);
    botoes_in[3] = 1'b0; steps(2);
    botoes_in[3] = 1'b1;
    steps(5);
    chk("release_held", {7'd0, botoes[3]}, 8'h01);
    step();
    chk("release_fall", {7'd0, botoes[3]}, 8'h00);
    chk("release_nopulse", 8'(pcount[3]), 8'd0);
    steps(4);

    // Reset at count 2 of the press window on button 4
    botoes_in[4] = 1'b0;
    steps(5);
    #2 reset = 1'b0;
    model_clear();
    #1 chk_all_zero("reset_mid");
    @(posedge clock); @(posedge clock);
    #3 reset = 1'b1;
    clear_counts();
    steps(5);
    chk("rst_nopulse", 8'(pcount[4]), 8'd0);
    step();
    chk("rst_pulse6", {1'b0, botoes_pulse}, 8'h10);
    botoes_in[4] = 1'b1; steps(10);

    // Held button 6 and held iniciar: repeat only on the game button
    botoes_in[6] = 1'b0; steps(5);
    clear_counts();
    steps(30);
    chk("hold6_pulses", 8'(pcount[6]), AR ? 8'd5 : 8'd1);
    botoes_in[6] = 1'b1; steps(10);
    iniciar_in = 1'b0; steps(5);
    clear_counts();
    steps(30);
    chk("hold_ini_pulses", 8'(pcount[7]), 8'd1);
    chk("hold_ini_jog", {1'b0, botoes_pulse}, 8'h00);
    iniciar_in = 1'b1; steps(10);

    // Random activity on all channels
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 7; c++)
        if ($urandom_range(5) == 0) botoes_in[c] = ~botoes_in[c];
      if ($urandom_range(7) == 0) iniciar_in = ~iniciar_in;
      zera_jogada = ($urandom_range(7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
